// File: rtl/dist_bit_packer.sv
// dist_bit_packer: packs variable-length codes MSB-first into fixed-width words, with flush.
module dist_bit_packer #(
  parameter int OUT_WIDTH  = 16,
  parameter int CODE_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  code_valid_in,
  input  logic [CODE_WIDTH-1:0] code_data_in,
  input  logic [4:0]            code_len_in,
  output logic                  code_ready_out,
  input  logic                  flush_in,
  output logic                  out_valid,
  output logic [OUT_WIDTH-1:0]  out_data,
  output logic [4:0]            out_nbits,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  flush_done,
  output logic [31:0]           bit_count
);
  localparam int AW = OUT_WIDTH + CODE_WIDTH;
  typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;
  state_t state, state_nx;
  logic [AW-1:0] acc, acc_nx, shifted, code_ext;
  logic [5:0] fill, fill_nx, consumed, base;
  logic [4:0] len_eff;
  logic in_hs, out_hs, last_word;
  always_comb begin
    len_eff        = code_len_in > 5'(CODE_WIDTH) ? 5'(CODE_WIDTH) : code_len_in;
    code_ready_out = state == RUN && fill <= 6'(OUT_WIDTH);
    last_word      = state == FLUSH && fill <= 6'(OUT_WIDTH);
    out_valid      = (state == RUN && fill >= 6'(OUT_WIDTH)) || (state == FLUSH && fill != 6'd0);
    out_data       = acc[AW-1 -: OUT_WIDTH];
    out_nbits      = out_valid ? (last_word ? 5'(fill) : 5'(OUT_WIDTH)) : 5'd0;
    out_last       = out_valid && last_word;
    flush_done     = state == DONE;
    in_hs          = code_valid_in && code_ready_out;
    out_hs         = out_valid && out_ready;
    consumed       = out_hs ? (last_word ? fill : 6'(OUT_WIDTH)) : 6'd0;
    base           = fill - consumed;
    shifted        = out_hs ? acc << OUT_WIDTH : acc;
    code_ext       = AW'(code_data_in) & ((AW'(1) << len_eff) - AW'(1));
    // New bits land directly behind whatever survives this cycle's output shift
    acc_nx         = in_hs ? shifted | (code_ext << (6'(AW) - base - 6'(len_eff))) : shifted;
    fill_nx        = base + (in_hs ? 6'(len_eff) : 6'd0);
    state_nx       = state == RUN   ? (flush_in ? FLUSH : RUN) :
                     state == FLUSH ? ((fill == 6'd0 || (out_hs && last_word)) ? DONE : FLUSH) :
                     RUN;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      acc       <= '0;
      fill      <= '0;
      bit_count <= '0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      fill      <= fill_nx;
      bit_count <= bit_count + (in_hs ? 32'(len_eff) : 32'd0);
    end
  end
endmodule

// File: tb/tb_dist_bit_packer.sv
// tb_dist_bit_packer: table-driven per-cycle vectors plus reset corner sequence.
module tb_dist_bit_packer;
  logic clk = 0, rst = 1;
  logic code_valid_in = 0, flush_in = 0, out_ready = 0;
  logic [17:0] code_data_in = '0;
  logic [4:0] code_len_in = '0;
  logic code_ready_out, out_valid, out_last, flush_done;
  logic [15:0] out_data;
  logic [4:0] out_nbits;
  logic [31:0] bit_count;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  dist_bit_packer dut (
    .clk(clk), .rst(rst), .code_valid_in(code_valid_in), .code_data_in(code_data_in),
    .code_len_in(code_len_in), .code_ready_out(code_ready_out), .flush_in(flush_in),
    .out_valid(out_valid), .out_data(out_data), .out_nbits(out_nbits), .out_last(out_last),
    .out_ready(out_ready), .flush_done(flush_done), .bit_count(bit_count)
  );

  typedef struct {
    logic v; logic [17:0] d; logic [4:0] l; logic f; logic ordy;
    logic rdy; logic ov; logic [15:0] od; logic [4:0] on; logic ol; logic dn; logic [31:0] bc;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic drive(input logic v, input logic [17:0] d, input logic [4:0] l, input logic f, input logic ordy);
    code_valid_in = v; code_data_in = d; code_len_in = l; flush_in = f; out_ready = ordy;
  endtask

  initial begin
    //                 v  data      len f  ordy rdy ov data     nb  last done bc
    vecs.push_back('{1, 18'h16,   5, 0, 1,  1, 0, 16'h0,    0,  0, 0, 0});
    vecs.push_back('{1, 18'h16,   5, 0, 1,  1, 0, 16'h0,    0,  0, 0, 5});
    vecs.push_back('{1, 18'h16,   5, 0, 1,  1, 0, 16'h0,    0,  0, 0, 10});
    vecs.push_back('{1, 18'h1,    1, 0, 1,  1, 0, 16'h0,    0,  0, 0, 15});
    vecs.push_back('{0, 18'h0,    0, 0, 1,  1, 1, 16'hB5AD, 16, 0, 0, 16});
    vecs.push_back('{0, 18'h0,    0, 0, 1,  1, 0, 16'h0,    0,  0, 0, 16});
    vecs.push_back('{1, 18'h5,    3, 0, 1,  1, 0, 16'h0,    0,  0, 0, 16});
    vecs.push_back('{0, 18'h0,    0, 1, 1,  1, 0, 16'h0,    0,  0, 0, 19});
    vecs.push_back('{0, 18'h0,    0, 0, 0,  0, 1, 16'hA000, 3,  1, 0, 19});
    vecs.push_back('{0, 18'h0,    0, 0, 1,  0, 1, 16'hA000, 3,  1, 0, 19});
    vecs.push_back('{0, 18'h0,    0, 0, 1,  0, 0, 16'h0,    0,  0, 1, 19});
    vecs.push_back('{0, 18'h0,    0, 0, 1,  1, 0, 16'h0,    0,  0, 0, 19});
    vecs.push_back('{1, 18'h3FFFF,18, 0, 0, 1, 0, 16'h0,    0,  0, 0, 19});
    vecs.push_back('{1, 18'h3FFFF,18, 0, 0, 0, 1, 16'hFFFF, 16, 0, 0, 37});
    vecs.push_back('{0, 18'h0,    0, 0, 0,  0, 1, 16'hFFFF, 16, 0, 0, 37});
    vecs.push_back('{0, 18'h0,    0, 0, 1,  0, 1, 16'hFFFF, 16, 0, 0, 37});
    vecs.push_back('{1, 18'h0,    14, 0, 0, 1, 0, 16'h0,    0,  0, 0, 37});
    vecs.push_back('{1, 18'h12345,18, 0, 1, 1, 1, 16'hC000, 16, 0, 0, 51});
    vecs.push_back('{0, 18'h0,    0, 0, 0,  0, 1, 16'h48D1, 16, 0, 0, 69});
    vecs.push_back('{0, 18'h0,    0, 1, 1,  0, 1, 16'h48D1, 16, 0, 0, 69});
    vecs.push_back('{0, 18'h0,    0, 0, 1,  0, 1, 16'h4000, 2,  1, 0, 69});
    vecs.push_back('{0, 18'h0,    0, 0, 1,  0, 0, 16'h0,    0,  0, 1, 69});
    vecs.push_back('{0, 18'h0,    0, 1, 1,  1, 0, 16'h0,    0,  0, 0, 69});
    vecs.push_back('{0, 18'h0,    0, 0, 1,  0, 0, 16'h0,    0,  0, 0, 69});
    vecs.push_back('{0, 18'h0,    0, 0, 1,  0, 0, 16'h0,    0,  0, 1, 69});
    vecs.push_back('{1, 18'h3FFFF,0, 0, 1,  1, 0, 16'h0,    0,  0, 0, 69});
    vecs.push_back('{1, 18'h3FFFF,31, 0, 0, 1, 0, 16'h0,    0,  0, 0, 69});
    vecs.push_back('{0, 18'h0,    0, 0, 0,  0, 1, 16'hFFFF, 16, 0, 0, 87});
    vecs.push_back('{0, 18'h0,    0, 0, 1,  0, 1, 16'hFFFF, 16, 0, 0, 87});
    vecs.push_back('{0, 18'h0,    0, 0, 0,  1, 0, 16'h0,    0,  0, 0, 87});

    repeat (2) @(negedge clk);
    #1;
    chk("reset ov", 32'(out_valid), 0);
    chk("reset nbits", 32'(out_nbits), 0);
    chk("reset done", 32'(flush_done), 0);
    chk("reset bc", bit_count, 0);
    rst = 0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].f, vecs[i].ordy);
      #1;
      chk($sformatf("v%0d rdy", i), 32'(code_ready_out), 32'(vecs[i].rdy));
      chk($sformatf("v%0d ov", i), 32'(out_valid), 32'(vecs[i].ov));
      chk($sformatf("v%0d done", i), 32'(flush_done), 32'(vecs[i].dn));
      chk($sformatf("v%0d bc", i), bit_count, vecs[i].bc);
      if (vecs[i].ov) begin
        chk($sformatf("v%0d data", i), 32'(out_data), 32'(vecs[i].od));
        chk($sformatf("v%0d nbits", i), 32'(out_nbits), 32'(vecs[i].on));
        chk($sformatf("v%0d last", i), 32'(out_last), 32'(vecs[i].ol));
      end
    end

    // fill is 2 here; add 8 bits to reach 10, then reset mid-stream
    @(negedge clk); drive(1, 18'hAB, 8, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0); rst = 1;
    @(negedge clk); #1;
    chk("rst mid ov", 32'(out_valid), 0);
    chk("rst mid nbits", 32'(out_nbits), 0);
    chk("rst mid last", 32'(out_last), 0);
    chk("rst mid done", 32'(flush_done), 0);
    chk("rst mid bc", bit_count, 0);
    chk("rst mid data", 32'(out_data), 0);
    rst = 0;
    @(negedge clk); #1;
    chk("post rst rdy", 32'(code_ready_out), 1);
    chk("post rst ov", 32'(out_valid), 0);
    drive(1, 18'hFFFF, 16, 0, 0);
    @(negedge clk); drive(0, 0, 0, 0, 1); #1;
    chk("post rst word ov", 32'(out_valid), 1);
    chk("post rst word data", 32'(out_data), 32'hFFFF);
    chk("post rst bc", bit_count, 16);
    @(negedge clk); #1;
    chk("post rst drained", 32'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
